// File: rtl/sram_stream_reader.sv
// sram_stream_reader: streams LEN consecutive SRAM words from BASE_ADDR over valid/ready
// Ports: clk_i/rst_i (sync active-high), start_i/base_addr_i/len_i request, busy_o/done_o status,
// sram_* read port (1-cycle registered-address read, never writes), m_* output stream.
// Optional SRAM_RD_CHECKSUM_EN adds checksum_o, the mod-2**32 sum of accepted words.
module sram_stream_reader #(
  parameter int AW = 14
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [AW:0]   len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] sram_addr_o,
  output logic          sram_cs_o,
  output logic [3:0]    sram_wren_o,
  output logic [31:0]   sram_wdata_o,
  input  logic [31:0]   sram_rdata_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [31:0]   m_data_o,
  output logic          m_last_o
`ifdef SRAM_RD_CHECKSUM_EN
  ,
  output logic [31:0]   checksum_o
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   issue_q, issue_d, emit_q, emit_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          infl_q, wp_q, wp_d, rp_q, rp_d, rd_en, pop;
  logic [31:0]   buf_q [2];
  logic [31:0]   buf_d [2];
  assign busy_o       = state_q == RUN;
  assign done_o       = state_q == DONE_ST;
  assign m_valid_o    = cnt_q != 2'd0;
  assign m_data_o     = buf_q[rp_q];
  assign m_last_o     = m_valid_o && emit_q == (AW+1)'(1);
  assign sram_cs_o    = rd_en;
  assign sram_addr_o  = addr_q;
  assign sram_wren_o  = 4'b0000;
  assign sram_wdata_o = 32'h0;
  assign pop          = m_valid_o & m_ready_i;
  // buffered + in-flight after this cycle's pop must leave room for one more word
  assign rd_en = state_q == RUN && issue_q != '0 &&
                 ({1'b0, cnt_q} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue_d = issue_q;
    emit_d  = emit_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q + 2'(infl_q) - 2'(pop);
    case (state_q)
      IDLE: if (start_i) begin
        state_d = (len_i == '0) ? DONE_ST : RUN;
        addr_d  = base_addr_i;
        issue_d = len_i;
        emit_d  = len_i;
      end
      RUN:     state_d = (pop && m_last_o) ? DONE_ST : RUN;
      default: state_d = IDLE;
    endcase
    if (rd_en) begin
      addr_d  = addr_q + AW'(1);
      issue_d = issue_q - (AW+1)'(1);
    end
    if (infl_q) begin
      buf_d[wp_q] = sram_rdata_i;
      wp_d        = ~wp_q;
    end
    if (pop) begin
      rp_d   = ~rp_q;
      emit_d = emit_q - (AW+1)'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      issue_q  <= '0;
      emit_q   <= '0;
      cnt_q    <= '0;
      infl_q   <= 1'b0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      issue_q <= issue_d;
      emit_q  <= emit_d;
      cnt_q   <= cnt_d;
      infl_q  <= rd_en;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      buf_q   <= buf_d;
    end
  end
`ifdef SRAM_RD_CHECKSUM_EN
  logic [31:0] sum_q;
  assign checksum_o = sum_q;
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_q == IDLE && start_i)) sum_q <= '0;
    else if (pop) sum_q <= sum_q + m_data_o;
  end
`endif
endmodule
